// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle MIPS-subset core with a req/ack data bus.
// Each instruction runs 3-5 FSM states; exposes cycle/instret counters.
module mc_cpu #(
  parameter int              XLEN     = 32,
  parameter int              IM_AW    = 10,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              RA_REG   = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IM_AW-1:0] imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_ack,
  output logic             halted,
  output logic [31:0]      cycles,
  output logic [31:0]      instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_WB, S_HALT
  } state_e;

  localparam logic [XLEN-1:0] ONE = 1;
  localparam logic [4:0]      RA  = 5'(RA_REG);
  localparam logic [5:0]      OP_LW = 6'h23;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   alu_q, alu_d;
  logic [XLEN-1:0]   npc_q, npc_d;
  logic [XLEN-1:0]   mdr_q, mdr_d;
  logic [4:0]        wa_q, wa_d;
  logic              req_q, req_d, we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [31:0]       cyc_q, cyc_d, ret_q, ret_d;
  logic [XLEN-1:0]   rf_q [32];
  logic              rf_we;
  logic [XLEN-1:0]   rf_wd;

  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd, sh;
  logic [XLEN-1:0]   simm, zimm, jt;
  logic [XLEN-1:0]   res, npc;
  logic [4:0]        wa;
  logic              go_wb, go_mem, go_halt, st;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign sh    = ir_q[10:6];
  assign funct = ir_q[5:0];
  assign simm  = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
  assign zimm  = {{(XLEN-16){1'b0}}, ir_q[15:0]};
  assign jt    = {{(XLEN-26){1'b0}}, ir_q[25:0]};

  always_comb begin
    res     = '0;
    npc     = pc_q + ONE;
    wa      = rt;
    go_wb   = 1'b0;
    go_mem  = 1'b0;
    go_halt = 1'b0;
    st      = 1'b0;
    case (op)
      6'h00: begin
        wa    = rd;
        go_wb = 1'b1;
        case (funct)
          6'h20: res = a_q + b_q;
          6'h22,
          6'h23: res = a_q - b_q;
          6'h24: res = a_q & b_q;
          6'h25: res = a_q | b_q;
          6'h26: res = a_q ^ b_q;
          6'h27: res = ~(a_q | b_q);
          6'h2A: res = XLEN'($signed(a_q) < $signed(b_q));
          6'h2B: res = XLEN'($signed(a_q) > $signed(b_q));
          6'h00: res = b_q << sh;
          6'h02: res = b_q >> sh;
          6'h08: begin
            npc   = a_q;
            go_wb = 1'b0;
          end
          default: go_wb = 1'b0;
        endcase
      end
      6'h08: begin res = a_q + simm; go_wb = 1'b1; end
      6'h2A: begin
        res   = XLEN'($signed(a_q) < $signed(simm));
        go_wb = 1'b1;
      end
      6'h0C: begin res = a_q & zimm; go_wb = 1'b1; end
      6'h0D: begin res = a_q | zimm; go_wb = 1'b1; end
      6'h0E: begin res = a_q ^ zimm; go_wb = 1'b1; end
      6'h23: begin res = a_q + simm; go_mem = 1'b1; end
      6'h2B: begin
        res    = a_q + simm;
        go_mem = 1'b1;
        st     = 1'b1;
      end
      6'h04: if (a_q == b_q) npc = pc_q + simm;
      6'h05: if (a_q != b_q) npc = pc_q + simm;
      6'h02: npc = jt;
      6'h03: begin
        res   = pc_q + ONE;
        wa    = RA;
        npc   = jt;
        go_wb = 1'b1;
      end
      6'h3F: go_halt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    npc_d   = npc_q;
    mdr_d   = mdr_q;
    wa_d    = wa_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ret_d   = ret_q;
    cyc_d   = cyc_q;
    rf_we   = 1'b0;
    rf_wd   = (op == OP_LW) ? mdr_q : alu_q;
    if (state_q != S_HALT) cyc_d = cyc_q + 32'd1;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = imem_rdata;
        a_d     = rf_q[imem_rdata[25:21]];
        b_d     = rf_q[imem_rdata[20:16]];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_d = res;
        npc_d = npc;
        wa_d  = wa;
        if (go_halt) begin
          state_d = S_HALT;
        end else if (go_mem) begin
          req_d   = 1'b1;
          we_d    = st;
          addr_d  = res;
          wdata_d = b_q;
          state_d = S_MEM;
        end else if (go_wb) begin
          state_d = S_WB;
        end else begin
          pc_d    = npc;
          ret_d   = ret_q + 32'd1;
          state_d = S_FETCH;
        end
      end
      S_MEM: if (mem_ack) begin
        req_d = 1'b0;
        if (we_q) begin
          pc_d    = npc_q;
          ret_d   = ret_q + 32'd1;
          state_d = S_FETCH;
        end else begin
          mdr_d   = mem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_d    = npc_q;
        ret_d   = ret_q + 32'd1;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      npc_q   <= '0;
      mdr_q   <= '0;
      wa_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      npc_q   <= npc_d;
      mdr_q   <= mdr_d;
      wa_q    <= wa_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
    end
  end

  // r0 is never written, so it reads as zero forever
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && wa_q != 5'd0) begin
      rf_q[wa_q] <= rf_wd;
    end
  end

  assign imem_addr = pc_q[IM_AW-1:0];
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign halted    = (state_q == S_HALT);
  assign cycles    = cyc_q;
  assign instret   = ret_q;

endmodule

// File: tb/tb_mc_cpu.sv
// tb_mc_cpu: directed program tests for mc_cpu with a
// sync ROM and a wait-state data memory model.
module tb_mc_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        halted;
  logic [31:0] cycles, instret;

  logic [31:0] rom  [1024];
  logic [31:0] dmem [64];
  int          wait_n;
  int          rcnt;
  int          n_wr;
  int          req_cyc;
  int          pass_n;
  int          total_n;

  mc_cpu dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halted(halted), .cycles(cycles), .instret(instret)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) imem_rdata <= rom[imem_addr];

  always @(negedge clk) begin
    if (rst || !mem_req) begin
      mem_ack = 1'b0;
      rcnt    = 0;
    end else begin
      mem_ack   = (rcnt == wait_n);
      mem_rdata = dmem[mem_addr[5:0]];
      rcnt++;
    end
  end

  always @(posedge clk) begin
    if (!rst && mem_req) begin
      req_cyc++;
      if (mem_ack && mem_we) begin
        dmem[mem_addr[5:0]] = mem_wdata;
        n_wr++;
      end
    end
  end

  localparam logic [31:0] HLT = 32'hFC00_0000;

  function automatic logic [31:0] rt_(input logic [5:0] f,
    input logic [4:0] s, input logic [4:0] t,
    input logic [4:0] d, input logic [4:0] sh);
    return {6'h00, s, t, d, sh, f};
  endfunction

  function automatic logic [31:0] it_(input logic [5:0] op,
    input logic [4:0] s, input logic [4:0] t,
    input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] jt_(input logic [5:0] op,
    input logic [25:0] tg);
    return {op, tg};
  endfunction

  task automatic setup(input int w);
    @(negedge clk);
    rst = 1'b1;
    wait_n = w;
    n_wr = 0;
    req_cyc = 0;
    for (int i = 0; i < 1024; i++) rom[i] = HLT;
    for (int i = 0; i < 64; i++) dmem[i] = 32'h1111_1111;
    dmem[4] = 32'hDEAD_BEEF;
  endtask

  task automatic go();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    setup(0);
    cyc(2);
    total_n++;
    if ({halted, mem_req, mem_we} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000",
               {halted, mem_req, mem_we});
    else pass_n++;
    total_n++;
    if ({cycles, instret} !== 64'd0)
      $display("FAIL reset_cnt: got %h/%h want 0/0", cycles, instret);
    else pass_n++;
    total_n++;
    if ({mem_addr, mem_wdata} !== 64'd0)
      $display("FAIL reset_bus: got %h/%h want 0/0",
               mem_addr, mem_wdata);
    else pass_n++;
    total_n++;
    if (imem_addr !== 10'd0)
      $display("FAIL reset_pc: got %h want 0", imem_addr);
    else pass_n++;
  endtask

  task automatic test_alu();
    setup(0);
    rom[0] = it_(6'h08, 0, 2, 16'd5);
    rom[1] = it_(6'h08, 0, 3, 16'hFFFD);
    rom[2] = rt_(6'h20, 2, 3, 4, 0);
    go();
    wait_halt(100);
    total_n++;
    if (halted !== 1'b1) $display("FAIL alu_halt: got %b want 1", halted);
    else pass_n++;
    total_n++;
    if (instret !== 32'd3) $display("FAIL alu_instret: got %0d want 3", instret);
    else pass_n++;
    total_n++;
    if (cycles !== 32'd15) $display("FAIL alu_cycles: got %0d want 15", cycles);
    else pass_n++;
    cyc(5);
    total_n++;
    if ({cycles, mem_req, halted} !== {32'd15, 1'b0, 1'b1})
      $display("FAIL halt_hold: got %0d/%b/%b want 15/0/1",
               cycles, mem_req, halted);
    else pass_n++;
  endtask

  task automatic test_alu_ops();
    logic [31:0] expv [15];
    logic [4:0]  r;
    expv = '{32'd2, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFF8,
             32'd2, 32'd1, 32'd0, 32'h50, 32'hF, 32'd1,
             32'h0000_FFFD, 32'h0000_8000, 32'hA, 32'd0};
    setup(0);
    rom[0]  = it_(6'h08, 0, 2, 16'd5);
    rom[1]  = it_(6'h08, 0, 3, 16'hFFFD);
    rom[2]  = rt_(6'h20, 2, 3, 4, 0);
    rom[3]  = rt_(6'h22, 2, 3, 5, 0);
    rom[4]  = rt_(6'h24, 2, 3, 6, 0);
    rom[5]  = rt_(6'h25, 2, 3, 7, 0);
    rom[6]  = rt_(6'h26, 2, 3, 8, 0);
    rom[7]  = rt_(6'h27, 2, 3, 9, 0);
    rom[8]  = rt_(6'h2A, 3, 2, 10, 0);
    rom[9]  = rt_(6'h2B, 3, 2, 11, 0);
    rom[10] = rt_(6'h00, 0, 2, 12, 4);
    rom[11] = rt_(6'h02, 0, 3, 13, 28);
    rom[12] = it_(6'h2A, 3, 14, 16'hFFFE);
    rom[13] = it_(6'h0C, 3, 15, 16'hFFFF);
    rom[14] = it_(6'h0D, 0, 16, 16'h8000);
    rom[15] = it_(6'h0E, 2, 17, 16'h000F);
    rom[16] = rt_(6'h20, 2, 2, 0, 0);
    for (int k = 0; k < 15; k++) begin
      r = (k < 14) ? 5'(4 + k) : 5'd0;
      rom[17 + k] = it_(6'h2B, 0, r, 16'(16 + k));
    end
    go();
    wait_halt(500);
    total_n++;
    if (halted !== 1'b1) $display("FAIL ops_halt: got %b want 1", halted);
    else pass_n++;
    for (int k = 0; k < 15; k++) begin
      total_n++;
      if (dmem[16 + k] !== expv[k])
        $display("FAIL ops_%0d: got %h want %h", k, dmem[16 + k], expv[k]);
      else pass_n++;
    end
  endtask

  task automatic test_load();
    setup(3);
    rom[0] = it_(6'h23, 0, 5, 16'd4);
    rom[1] = it_(6'h2B, 0, 5, 16'd5);
    go();
    cyc(4);
    total_n++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'd4})
      $display("FAIL lw_bus: got %b/%b/%h want 1/0/4",
               mem_req, mem_we, mem_addr);
    else pass_n++;
    cyc(2);
    total_n++;
    if ({mem_req, mem_addr} !== {1'b1, 32'd4})
      $display("FAIL lw_hold: got %b/%h want 1/4", mem_req, mem_addr);
    else pass_n++;
    cyc(1);
    total_n++;
    if (imem_addr !== 10'd0)
      $display("FAIL lw_lat7: got %0d want 0", imem_addr);
    else pass_n++;
    cyc(1);
    total_n++;
    if (imem_addr !== 10'd1)
      $display("FAIL lw_lat8: got %0d want 1", imem_addr);
    else pass_n++;
    wait_halt(100);
    total_n++;
    if (dmem[5] !== 32'hDEAD_BEEF)
      $display("FAIL lw_data: got %h want deadbeef", dmem[5]);
    else pass_n++;
    total_n++;
    if ({cycles, instret} !== {32'd18, 32'd2})
      $display("FAIL lw_cnt: got %0d/%0d want 18/2", cycles, instret);
    else pass_n++;
  endtask

  task automatic test_store();
    setup(0);
    rom[0] = it_(6'h08, 0, 2, 16'd5);
    rom[1] = it_(6'h2B, 0, 2, 16'd8);
    go();
    cyc(7);
    total_n++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !==
        {1'b1, 1'b1, 32'd8, 32'd5})
      $display("FAIL sw_bus: got %b/%b/%h/%h want 1/1/8/5",
               mem_req, mem_we, mem_addr, mem_wdata);
    else pass_n++;
    wait_halt(100);
    total_n++;
    if (req_cyc !== 1) $display("FAIL sw_reqcyc: got %0d want 1", req_cyc);
    else pass_n++;
    total_n++;
    if (dmem[8] !== 32'd5) $display("FAIL sw_data: got %h want 5", dmem[8]);
    else pass_n++;
    total_n++;
    if ({cycles, instret} !== {32'd11, 32'd2})
      $display("FAIL sw_cnt: got %0d/%0d want 11/2", cycles, instret);
    else pass_n++;
  endtask

  task automatic test_branch();
    setup(0);
    rom[0]  = it_(6'h08, 0, 2, 16'd5);
    rom[1]  = jt_(6'h02, 26'd10);
    rom[10] = it_(6'h05, 2, 0, 16'hFFFE);
    rom[11] = it_(6'h08, 0, 2, 16'd1);
    go();
    cyc(7);
    total_n++;
    if (imem_addr !== 10'd10) $display("FAIL j_pc: got %0d want 10", imem_addr);
    else pass_n++;
    cyc(3);
    total_n++;
    if (imem_addr !== 10'd8) $display("FAIL bne_t: got %0d want 8", imem_addr);
    else pass_n++;
    wait_halt(100);
    total_n++;
    if ({cycles, instret} !== {32'd13, 32'd3})
      $display("FAIL bne_t_cnt: got %0d/%0d want 13/3", cycles, instret);
    else pass_n++;

    setup(0);
    rom[0]  = jt_(6'h02, 26'd10);
    rom[10] = it_(6'h05, 2, 0, 16'hFFFE);
    rom[11] = it_(6'h04, 0, 0, 16'd3);
    rom[14] = 32'hF800_0000;
    go();
    cyc(6);
    total_n++;
    if (imem_addr !== 10'd11) $display("FAIL bne_nt: got %0d want 11", imem_addr);
    else pass_n++;
    cyc(3);
    total_n++;
    if (imem_addr !== 10'd14) $display("FAIL beq_t: got %0d want 14", imem_addr);
    else pass_n++;
    wait_halt(100);
    total_n++;
    if ({cycles, instret} !== {32'd15, 32'd4})
      $display("FAIL nop_cnt: got %0d/%0d want 15/4", cycles, instret);
    else pass_n++;
  endtask

  task automatic test_jal();
    setup(0);
    rom[0]  = jt_(6'h02, 26'd7);
    rom[7]  = jt_(6'h03, 26'h40);
    rom[64] = rt_(6'h08, 1, 0, 0, 0);
    rom[8]  = it_(6'h2B, 0, 1, 16'd20);
    go();
    cyc(7);
    total_n++;
    if (imem_addr !== 10'h40) $display("FAIL jal_pc: got %h want 40", imem_addr);
    else pass_n++;
    cyc(3);
    total_n++;
    if (imem_addr !== 10'd8) $display("FAIL jr_pc: got %0d want 8", imem_addr);
    else pass_n++;
    wait_halt(100);
    total_n++;
    if (dmem[20] !== 32'd8) $display("FAIL jal_ra: got %h want 8", dmem[20]);
    else pass_n++;
    total_n++;
    if ({cycles, instret} !== {32'd17, 32'd4})
      $display("FAIL jal_cnt: got %0d/%0d want 17/4", cycles, instret);
    else pass_n++;
  endtask

  task automatic test_rst_mem();
    setup(5);
    rom[0] = it_(6'h08, 0, 2, 16'd5);
    rom[1] = it_(6'h2B, 0, 2, 16'd9);
    go();
    cyc(8);
    total_n++;
    if (mem_req !== 1'b1) $display("FAIL rm_pre: got %b want 1", mem_req);
    else pass_n++;
    rst = 1'b1;
    #1;
    total_n++;
    if (mem_req !== 1'b0) $display("FAIL rm_req: got %b want 0", mem_req);
    else pass_n++;
    total_n++;
    if ({imem_addr, cycles, instret} !== {10'd0, 32'd0, 32'd0})
      $display("FAIL rm_state: got %0d/%0d/%0d want 0/0/0",
               imem_addr, cycles, instret);
    else pass_n++;
    cyc(3);
    total_n++;
    if ({n_wr, dmem[9]} !== {32'd0, 32'h1111_1111})
      $display("FAIL rm_mem: got %0d/%h want 0/11111111", n_wr, dmem[9]);
    else pass_n++;
  endtask

  initial begin
    pass_n = 0;
    total_n = 0;
    wait_n = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_alu();
    test_alu_ops();
    test_load();
    test_store();
    test_branch();
    test_jal();
    test_rst_mem();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/mc_cpu.md
# mc_cpu

Parametrised multi-cycle successor to the team's single-cycle MIPS-subset core: same instruction encoding and register conventions, but executes each instruction over 3–5 FSM states and accesses data memory through a req/ack handshake that tolerates arbitrary wait states. Sits between a synchronous-read instruction ROM and the data-memory/peripheral bus. It exposes cycle and retired-instruction counters for benchmarking.

## Interface
- XLEN, 32: datapath and register width (≥32); instruction word is always 32 bits.
- IM_AW, 10: instruction address width; imem_addr = PC[IM_AW-1:0].
- RESET_PC, 0: PC loaded on reset (word address).
- RA_REG, 1: link register written by JAL.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- imem_addr  out  IM_AW  instruction fetch address; ROM returns data one clock later.
- imem_rdata  in  32  instruction word.
- mem_req  out  1  data access request.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req.
- mem_addr  out  XLEN  data word address.
- mem_wdata  out  XLEN  store data.
- mem_rdata  in  XLEN  load data, sampled on the mem_ack cycle.
- mem_ack  in  1  completes the access in the cycle it is high with mem_req.
- halted  out  1  high in HALT state.
- cycles  out  32  clocks since reset, frozen in HALT.
- instret  out  32  retired instructions (HLT not counted).

## Operation
- Opcode IR[31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0], imm [15:0], target [25:0].
- R-type (op 0x00), funct: ADD/ADDU 0x20, SUB/SUBU 0x22/0x23, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLT 0x2A, SGT 0x2B (signed), SLL 0x00/SRL 0x02 (rt shifted by shamt), JR 0x08 (PC←rs, no register write). Destination rd.
- I-type, destination rt: ADDI 0x08, SLTI 0x2A (sign-extended imm); ANDI 0x0C, ORI 0x0D, XORI 0x0E (zero-extended imm); LW 0x23, SW 0x2B (addr = rs + sext(imm)).
- BEQ 0x04 / BNE 0x05: taken → PC ← PC + sext(imm); not taken → PC+1.
- J 0x02: PC ← zext(target). JAL 0x03: also reg[RA_REG] ← PC+1.
- HLT 0x3F: enter HALT.
- Unknown opcode/funct: no-op, PC+1, counted in instret.
- r0 reads as zero; writes to it are discarded. All arithmetic mod 2^XLEN; no overflow traps.
- States: FETCH → DECODE → EXEC → {MEM → WB | WB | FETCH}; HALT.
  - FETCH: imem_addr = PC.
  - DECODE: IR ← imem_rdata; A ← reg[rs], B ← reg[rt].
  - EXEC: ALU result latched. Branch, J, JR, no-op and HLT resolve here and go to FETCH (HALT for HLT). LW/SW go to MEM; others go to WB.
  - MEM: mem_req=1 until mem_ack. LW then goes to WB; SW completes on the ack cycle and goes to FETCH.
  - WB: write register file, PC ← PC+1 or jump target, go to FETCH.
- instret increments on the cycle the instruction leaves its last state.

## Timing
- Reset values: PC=RESET_PC, state FETCH, all registers 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, cycles=0, instret=0, imem_addr=RESET_PC[IM_AW-1:0].
- Latency, zero-wait memory:
  - branch/J/JR/no-op: 3 cycles.
  - ALU/JAL: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - Each wait state adds 1 cycle.
- mem_req, mem_we, mem_addr and mem_wdata are registered and held stable from MEM entry through the ack cycle. mem_req deasserts the cycle after the ack.
- mem_ack is ignored when mem_req=0. An ack in the first MEM cycle means zero wait states.
- Reset during MEM drops mem_req immediately (async); the transaction is abandoned and no write occurs.
- HALT: all outputs hold except mem_req=0; exit only via rst.
- PC wraps mod 2^XLEN; imem_addr uses only the low IM_AW bits.
- cycles counts every non-reset clock until HALT entry, inclusive of the HLT's EXEC cycle.

## Test plan
- ADDI r2,r0,5; ADDI r3,r0,-3; ADD r4,r2,r3; HLT → r4=2, instret=3, cycles=3·4+3=15, halted=1.
- LW r5,4(r0) with ack delayed 3 cycles, mem_rdata=0xDEADBEEF → mem_addr=4, mem_we=0, r5=0xDEADBEEF, LW takes 8 cycles.
- SW r2,8(r0) (r2=5), zero-wait ack → one mem_req cycle, mem_we=1, mem_addr=8, mem_wdata=5, no register written.
- BNE r2,r0,-2 at PC=10 with r2≠0 → next fetch PC=8; with r2=0 → PC=11.
- JAL 0x40 at PC=7, then JR r1 → r1=8, fetch at 0x40, then fetch at 8.
- Assert rst mid-MEM during a wait state → mem_req=0 in the same cycle, PC=RESET_PC, counters 0, memory untouched.
